// File: rtl/core_decode_fifo.sv
// Instruction buffer between fetch and decode: DEPTH-entry circular queue plus a registered decode input.
// Build option DECODE_FIFO_BYPASS_EN lets an instruction skip the empty queue straight into the output register.
module core_decode_fifo #(
  parameter int INSN_W = 16,
  parameter int PC_W   = 31,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INSN_W-1:0]            in_insn,
  input  logic [PC_W-1:0]              in_pc,
  input  logic                         stall,
  input  logic                         flush,
  output logic                         out_valid,
  output logic [INSN_W-1:0]            out_insn,
  output logic [PC_W-1:0]              out_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [INSN_W-1:0] q_insn [DEPTH];
  logic [PC_W-1:0]   q_pc   [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic              empty, byp, push, pop;

  always_comb begin
    empty    = (count == '0);
    in_ready = (count != FULL);
    byp      = 1'b0;
`ifdef DECODE_FIFO_BYPASS_EN
    byp      = in_valid && empty && !stall && !flush;
`endif
    pop      = !stall && !empty;
    // Flush discards a concurrent fetch even while in_ready reads 1.
    push     = in_valid && in_ready && !flush && !byp;
  end

  // Storage needs no reset: occupancy is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      q_insn[wr_ptr] <= in_insn;
      q_pc[wr_ptr]   <= in_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_insn  <= '0;
      out_pc    <= '0;
    end else if (flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_insn  <= '0;
      out_pc    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (!stall) begin
        if (pop) begin
          out_valid <= 1'b1;
          out_insn  <= q_insn[rd_ptr];
          out_pc    <= q_pc[rd_ptr];
        end else if (byp) begin
          out_valid <= 1'b1;
          out_insn  <= in_insn;
          out_pc    <= in_pc;
        end else begin
          // Empty queue: present a NOP, keep the last pc.
          out_valid <= 1'b0;
          out_insn  <= '0;
        end
      end
    end
  end
endmodule
